mem_bist_master: RTL and testbench

MEM_BIST_MASTER -- requirements
Module: mem_bist_master

---
 rtl/mem_bist_master.sv | 211 +++++++++++++++++++++
 tb/tb_mem_bist_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes a seeded address pattern over a word range of a
// no-waitrequest single-port RAM, reads it back, and counts mismatches.
module mem_bist_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 10000,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_lat;
  logic [ADDR_W-1:0] count_lat;
  logic [DATA_W-1:0] seed_lat;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        drain_cnt;

  // Read-compare pipeline, stage k holds the read issued k cycles earlier.
  logic              vld_p  [1:READ_LATENCY];
  logic [ADDR_W-1:0] addr_p [1:READ_LATENCY];

  logic              start_acc;
  logic              abort_acc;
  logic              mismatch;
  logic [15:0]       err_next;

  // Expected word for address a: seed ^ {a[13:0], 4'hA, a[13:0]}.
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    logic [13:0] a14;
    a14 = 14'(a);
    return s ^ DATA_W'({a14, 4'hA, a14});
  endfunction

  // Next word address with wrap from DEPTH-1 back to 0.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // Saturating increment of the mismatch counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode of accepted start/abort and the compare result of the current cycle.
  always_comb begin
    start_acc = (state == IDLE) && start;
    abort_acc = (state inside {WRITE, READ, DRAIN}) && abort;
    mismatch  = vld_p[READ_LATENCY] &&
                (avm_readdata != pattern(seed_lat, addr_p[READ_LATENCY]));
    err_next  = mismatch ? sat_inc(err_count) : err_count;
  end

  // Run parameters captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      base_lat  <= base_addr;
      count_lat <= word_count;
      seed_lat  <= seed;
    end
  end

  // Sequencer: IDLE -> WRITE -> READ -> DRAIN -> DONE, with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_clken      <= 1'b0;
      issue_cnt      <= '0;
      drain_cnt      <= '0;
    end else begin
      avm_clken <= 1'b1;
      if (abort_acc) begin
        state          <= IDLE;
        busy           <= 1'b0;
        avm_chipselect <= 1'b0;
        avm_write      <= 1'b0;
        avm_byteenable <= 4'h0;
        avm_address    <= '0;
        avm_writedata  <= '0;
      end else begin
        case (state)
          IDLE: begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            if (start) begin
              if (word_count == '0) begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state          <= WRITE;
                busy           <= 1'b1;
                done           <= 1'b0;
                pass           <= 1'b0;
                avm_chipselect <= 1'b1;
                avm_write      <= 1'b1;
                avm_byteenable <= 4'hF;
                avm_address    <= base_addr;
                avm_writedata  <= pattern(seed, base_addr);
                issue_cnt      <= ADDR_W'(1);
                next_addr      <= wrap_inc(base_addr);
              end
            end
          end
          WRITE: begin
            if (issue_cnt == count_lat) begin
              state         <= READ;
              avm_write     <= 1'b0;
              avm_address   <= base_lat;
              avm_writedata <= '0;
              issue_cnt     <= ADDR_W'(1);
              next_addr     <= wrap_inc(base_lat);
            end else begin
              avm_address   <= next_addr;
              avm_writedata <= pattern(seed_lat, next_addr);
              issue_cnt     <= issue_cnt + ADDR_W'(1);
              next_addr     <= wrap_inc(next_addr);
            end
          end
          READ: begin
            if (issue_cnt == count_lat) begin
              state          <= DRAIN;
              avm_chipselect <= 1'b0;
              avm_byteenable <= 4'h0;
              avm_address    <= '0;
              drain_cnt      <= '0;
            end else begin
              avm_address <= next_addr;
              issue_cnt   <= issue_cnt + ADDR_W'(1);
              next_addr   <= wrap_inc(next_addr);
            end
          end
          DRAIN: begin
            // The last compare lands on this edge, so pass uses err_next.
            if (drain_cnt == 8'(READ_LATENCY - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 16'd0);
            end else begin
              drain_cnt <= drain_cnt + 8'd1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Compare control: read-valid delay line and mismatch bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      for (int k = 1; k <= READ_LATENCY; k++) vld_p[k] <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= '0;
    end else if (abort_acc) begin
      for (int k = 1; k <= READ_LATENCY; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[1] <= avm_chipselect && !avm_write;
      for (int k = 2; k <= READ_LATENCY; k++) vld_p[k] <= vld_p[k-1];
      err_count <= err_next;
      if (mismatch && (err_count == 16'd0)) first_err_addr <= addr_p[READ_LATENCY];
    end
  end

  // Compare data: delayed copy of the read address.
  always_ff @(posedge clk) begin
    addr_p[1] <= avm_address;
    for (int k = 2; k <= READ_LATENCY; k++) addr_p[k] <= addr_p[k-1];
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: RAM model with read-side fault injection,
// directed scenarios plus randomized runs against a transaction-level model.
module tb_mem_bist_master;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 10000;
  localparam int RL     = 1;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [ADDR_W-1:0] base_addr, word_count;
  logic [31:0]       seed;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr, avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect, avm_write, avm_clken;
  logic [31:0]       avm_writedata, avm_readdata;

  mem_bist_master #(.ADDR_W(ADDR_W), .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_clken(avm_clken), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, optional bit flips applied on read.
  logic [31:0] mem  [0:DEPTH-1];
  logic [31:0] flip [0:DEPTH-1];
  always @(posedge clk) begin
    if (avm_chipselect) begin
      if (avm_write) mem[int'(avm_address)] <= avm_writedata;
      else avm_readdata <= mem[int'(avm_address)] ^ flip[int'(avm_address)];
    end
  end

  // Bus monitor.
  bit          mon_en = 1'b0;
  int          busy_cyc;
  int          wr_a[$], rd_a[$];
  logic [31:0] wr_d[$];
  logic [3:0]  wr_be[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cyc++;
      if (avm_chipselect) begin
        if (avm_write) begin
          wr_a.push_back(int'(avm_address));
          wr_d.push_back(avm_writedata);
          wr_be.push_back(avm_byteenable);
        end else begin
          rd_a.push_back(int'(avm_address));
        end
      end
    end
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pattern from plain arithmetic on the address.
  function automatic logic [31:0] exp_pat(input logic [31:0] s, input int a);
    int lo;
    lo = a % 16384;
    return s ^ 32'((lo << 18) | (10 << 14) | lo);
  endfunction

  // Full run: drive start, wait for done, compare bus traffic and results.
  task automatic run_bist(input int b, input int c, input logic [31:0] s,
                          input bit poke, input string tag, output int waited);
    int  exp_err, exp_first, a;
    bit  got_done;
    wr_a.delete(); rd_a.delete(); wr_d.delete(); wr_be.delete();
    busy_cyc = 0;
    mon_en   = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(b); word_count = ADDR_W'(c); seed = s;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    waited = -1;
    for (int n = 0; n < 2 * c + RL + 10; n++) begin
      if (done) begin got_done = 1'b1; waited = n; break; end
      if (poke && n == 1) begin
        start = 1'b1; base_addr = ADDR_W'((b + 17) % DEPTH); word_count = ADDR_W'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    mon_en = 1'b0;
    chk({tag, "_done_seen"}, got_done, 1);
    exp_err = 0; exp_first = 0;
    for (int i = 0; i < c; i++) begin
      a = (b + i) % DEPTH;
      if (flip[a] != 0) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pass"}, pass, (exp_err == 0));
    chk({tag, "_err_count"}, err_count, exp_err);
    chk({tag, "_first_err"}, first_err_addr, exp_first);
    chk({tag, "_busy_cycles"}, busy_cyc, (c == 0) ? 0 : 2 * c + RL);
    chk({tag, "_n_writes"}, wr_a.size(), c);
    chk({tag, "_n_reads"}, rd_a.size(), c);
    if (wr_a.size() == c && rd_a.size() == c) begin
      for (int i = 0; i < c; i++) begin
        a = (b + i) % DEPTH;
        chk({tag, "_wr_addr"}, wr_a[i], a);
        chk({tag, "_wr_data"}, wr_d[i], exp_pat(s, a));
        chk({tag, "_wr_be"}, wr_be[i], 4'hF);
        chk({tag, "_rd_addr"}, rd_a[i], a);
      end
    end
  endtask

  logic [31:0] k1 [4];
  int          k2 [4];
  int          w, reads, b, c;
  bit          aborted;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; flip[i] = '0; end
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_clken", avm_clken, 0);
    chk("rst_addr", avm_address, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("clken_run", avm_clken, 1);
    chk("idle_addr", avm_address, 0);
    chk("idle_wdata", avm_writedata, 0);

    // Scenario: base 0, count 4, seed 0.
    run_bist(0, 4, 32'h0, 1'b0, "basic", w);
    k1 = '{32'h00028000, 32'h00068001, 32'h000A8002, 32'h000E8003};
    if (wr_d.size() == 4)
      for (int i = 0; i < 4; i++) chk("basic_const_wd", wr_d[i], k1[i]);
    chk("basic_busy9", busy_cyc, 9);

    // Scenario: bit 0 of address 2 flipped on read.
    flip[2] = 32'h1;
    run_bist(0, 4, 32'h0, 1'b0, "flip2", w);
    chk("flip2_const_err", err_count, 1);
    chk("flip2_const_first", first_err_addr, 2);
    chk("flip2_const_pass", pass, 0);
    flip[2] = '0;

    // Scenario: zero-length run.
    run_bist(0, 0, 32'h1234, 1'b0, "zero", w);
    chk("zero_latency", w, 0);

    // Scenario: wrap at top of memory.
    run_bist(9998, 4, 32'hCAFE0001, 1'b0, "wrap", w);
    k2 = '{9998, 9999, 0, 1};
    if (rd_a.size() == 4 && wr_a.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("wrap_const_rd", rd_a[i], k2[i]);
        chk("wrap_const_wr", wr_a[i], k2[i]);
      end

    // Scenario: abort in the second read cycle.
    @(negedge clk);
    start = 1'b1; base_addr = 14'd100; word_count = 14'd4; seed = $urandom;
    @(negedge clk);
    start = 1'b0; reads = 0; aborted = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (avm_chipselect && !avm_write) reads++;
      if (reads == 2) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_cs", avm_chipselect, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_seen", aborted, 1);
    run_bist(100, 4, 32'h5A5A5A5A, 1'b0, "after_abort", w);

    // Scenario: reset during WRITE.
    @(negedge clk);
    start = 1'b1; base_addr = 14'd50; word_count = 14'd8; seed = 32'h0F0F0F0F;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_in_write", avm_write, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_first", first_err_addr, 0);
    chk("midrst_addr", avm_address, 0);
    chk("midrst_be", avm_byteenable, 0);
    chk("midrst_cs", avm_chipselect, 0);
    chk("midrst_wr", avm_write, 0);
    chk("midrst_wd", avm_writedata, 0);
    chk("midrst_clken", avm_clken, 0);
    reset = 1'b0;
    run_bist(50, 8, 32'hFFFFFFFF, 1'b0, "after_rst", w);

    // Randomized runs with random read faults and ignored mid-run starts.
    for (int r = 0; r < 10; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, 40);
      for (int i = 0; i < c; i++)
        if ($urandom_range(0, 7) == 0) flip[(b + i) % DEPTH] = 32'h1 << $urandom_range(0, 31);
      run_bist(b, c, $urandom, bit'($urandom_range(0, 1)), "rand", w);
      for (int i = 0; i < c; i++) flip[(b + i) % DEPTH] = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
